fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Fetch stage of the 5-stage pipeline; sits directly upstream of decode. Consumes stall_F/flush_F and the jump redirect produced alongside the hazard unit.
- Generates the PC and issues requests to instruction memory over a single-outstanding req/ack handshake.
- Buffers returned instructions in a small FIFO and presents {instr, pc, pc+4} to decode with a valid flag.
- Handles redirects, replays and discarding of stale in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- FIFO_DEPTH, 2, number of fetched-instruction entries held for decode (power of 2, ≥2).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- stall_F  input  1  hold: decode does not consume the head entry this cycle
- flush_F  input  1  discard buffered and in-flight instructions; replay
- jumping  input  1  redirect request this cycle
- jump_target  input  32  redirect PC
- imem_req  output  1  instruction memory request
- imem_addr  output  32  request address, word aligned
- imem_ack  input  1  response valid; completes current request
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- valid_D  output  1  head entry valid
- instr_D  output  32  head instruction
- pc_D  output  32  head PC
- pc_plus4_D  output  32  head PC + 4
- misalign_D  output  1  head flags misaligned target (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, FIFO empty, state=RUN, imem_req=0, valid_D=0, instr_D=0, pc_D=0, pc_plus4_D=0, misalign_D=0. First imem_req asserts in the first cycle after reset deasserts.
- States:
  - RUN: normal fetching.
  - DROP: an outstanding request must complete and its data must be discarded.
  - HALT: optional feature only.
- Issue rule (RUN): imem_req=1 when no request is outstanding and (fifo_count + outstanding) < FIFO_DEPTH. imem_addr=fetch_pc.
- Once imem_req is asserted, imem_req and imem_addr hold stable until the cycle imem_ack=1. Ack in the same cycle as the request is legal, giving a 0-wait fetch.
- On ack in RUN: push {imem_rdata, fetch_pc} into the FIFO; fetch_pc += 4 (mod 2^32, wraps 0xFFFFFFFC→0). A new request may issue the next cycle.
- Pop: the head is removed at posedge when valid_D=1 and stall_F=0. Push and pop in the same cycle are both performed. The space reservation guarantees the FIFO never overflows.
- Outputs are combinational from the FIFO head. pc_plus4_D = pc_D + 4, 32-bit wrap.
- Throughput with 0-wait memory and no stalls: 1 instruction/cycle. First valid_D appears 1 cycle after the first ack.
- jumping=1 (highest priority, any state):
  - FIFO cleared at the next edge; valid_D=0 the following cycle.
  - fetch_pc = jump_target.
  - If a request is outstanding and not acked this cycle, go to DROP. Otherwise stay in RUN.
  - An ack in the same cycle as jumping is discarded.
- flush_F=1 with jumping=0:
  - FIFO cleared.
  - fetch_pc = head pc_D if valid_D=1; otherwise the PC of the oldest in-flight request, or the unchanged fetch_pc.
  - Outstanding request handled as for jumping.
- DROP: imem_req stays high with the old address until ack. The acked data is discarded, then the state returns to RUN and fetch_pc is issued next cycle. A further jump in DROP updates fetch_pc only.
- stall_F does not block issue; fetching continues until the FIFO is full.
- Reset mid-request: the request is abandoned immediately (imem_req=0). Memory must tolerate this.

Optional Feature:
- FETCH_MISALIGN_CHECK_EN defined:
  - A jump_target with [1:0]≠0 enters HALT: no requests are issued.
  - A single FIFO entry {instr=32'h00000013, pc=jump_target} is pushed with misalign_D=1.
  - Only the next jumping (or reset) leaves HALT.
- Not defined: jump_target[1:0] is forced to 00, HALT is unreachable, and misalign_D is tied 0.

Test Plan:
- Reset, then 0-wait memory returning addr as data, no stalls → imem_addr 0,4,8,…; valid_D from cycle 2; pc_D/instr_D = 0,4,8 consecutively; pc_plus4_D = 4,8,12.
- stall_F held high 5 cycles → exactly FIFO_DEPTH (2) entries accepted, imem_req=0 while full; release → pc_D continues 0x8, 0xC with no loss or duplicate.
- Memory with 3-cycle ack latency; jumping=1, jump_target=0x100 one cycle after request to 0x10 → req held at 0x10 until ack, that data is dropped, next imem_addr=0x100, first valid pc_D=0x100.
- Head pc_D=0x20 valid, flush_F=1 → valid_D=0 next cycle, refetch from 0x20, pc_D=0x20 reappears.
- jumping and flush_F together (target 0x200), ack same cycle → ack data discarded, next fetch 0x200; reset asserted mid-request → imem_req=0, valid_D=0 immediately, refetch from RESET_PC.
- With FETCH_MISALIGN_CHECK_EN: jump to 0x102 → one entry misalign_D=1, pc_D=0x102, no imem_req until jump to 0x300.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, single-outstanding imem req/ack handshake and a small
// instruction FIFO feeding decode. Define FETCH_MISALIGN_CHECK_EN to trap misaligned jumps.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_F,
   input  logic        flush_F,
   input  logic        jumping,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        valid_D,
   output logic [31:0] instr_D,
   output logic [31:0] pc_D,
   output logic [31:0] pc_plus4_D,
   output logic        misalign_D
);
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {RUN, DROP, HALT} state_t;

   state_t        state, state_n;
   logic [31:0]   fetch_pc, pc_n, addr_n;
   logic [PW-1:0] rd_ptr, wr_ptr, rd_n, wr_n, wr_idx;
   logic [CW-1:0] count, count_n;
   logic          req_n, wr_en, waiting, pop, push_run, bad_target;
   logic [31:0]   target, wr_instr, wr_pc;
   logic [31:0]   instr_q [FIFO_DEPTH];
   logic [31:0]   pc_q    [FIFO_DEPTH];

`ifdef FETCH_MISALIGN_CHECK_EN
   logic          mis_q [FIFO_DEPTH];
   logic          wr_mis;
   assign target     = jump_target;
   assign bad_target = (jump_target[1:0] != 2'b00);
   assign misalign_D = valid_D && mis_q[rd_ptr];
`else
   assign target     = jump_target & 32'hFFFF_FFFC;
   assign bad_target = 1'b0;
   assign misalign_D = 1'b0;
`endif

   // A request is outstanding for as long as imem_req is high; it completes on ack.
   assign waiting    = imem_req && !imem_ack;
   assign valid_D    = (count != '0);
   assign pop        = valid_D && !stall_F;
   assign push_run   = imem_req && imem_ack && (state == RUN) && !jumping && !flush_F;
   assign instr_D    = valid_D ? instr_q[rd_ptr] : '0;
   assign pc_D       = valid_D ? pc_q[rd_ptr] : '0;
   assign pc_plus4_D = valid_D ? pc_q[rd_ptr] + 32'd4 : '0;

   always_comb begin
      state_n  = state;
      pc_n     = fetch_pc;
      count_n  = count;
      rd_n     = rd_ptr;
      wr_n     = wr_ptr;
      wr_en    = 1'b0;
      wr_idx   = wr_ptr;
      wr_instr = imem_rdata;
      wr_pc    = imem_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
      wr_mis   = 1'b0;
`endif
      if (jumping) begin
         pc_n    = target;
         count_n = '0;
         rd_n    = '0;
         wr_n    = '0;
         if (bad_target) begin
            // Trap entry goes into the freshly cleared FIFO at slot 0.
            state_n  = HALT;
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_instr = NOP;
            wr_pc    = target;
            wr_n     = PW'(1);
            count_n  = CW'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
            wr_mis   = 1'b1;
`endif
         end else begin
            state_n = waiting ? DROP : RUN;
         end
      end else if (flush_F) begin
         pc_n    = valid_D ? pc_q[rd_ptr] : fetch_pc;
         count_n = '0;
         rd_n    = '0;
         wr_n    = '0;
         if (state != HALT)
            state_n = waiting ? DROP : RUN;
      end else begin
         if (push_run) begin
            wr_en = 1'b1;
            wr_n  = wr_ptr + 1'b1;
            pc_n  = fetch_pc + 32'd4;
         end
         if (pop)
            rd_n = rd_ptr + 1'b1;
         count_n = count + CW'(push_run) - CW'(pop);
         if (state == DROP && imem_req && imem_ack)
            state_n = RUN;
      end
      // Issuing only when count_n < depth reserves the slot the response will use.
      req_n  = waiting || (state_n == RUN && count_n < CW'(FIFO_DEPTH));
      addr_n = waiting ? imem_addr : pc_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         fetch_pc  <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_n;
         fetch_pc  <= pc_n;
         rd_ptr    <= rd_n;
         wr_ptr    <= wr_n;
         count     <= count_n;
         imem_req  <= req_n;
         imem_addr <= addr_n;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         instr_q[wr_idx] <= wr_instr;
         pc_q[wr_idx]    <= wr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
         mis_q[wr_idx]   <= wr_mis;
`endif
      end
   end
endmodule
